rx_phyretrain_resolver: RTL and testbench
=========================================

// Module: rx_phyretrain_resolver
// PURPOSE
// - Parametrised RX-side PHYRETRAIN responder for the LTSM.
// - Waits for the partner's PHYRETRAIN start request over sideband and resolves local vs partner
//   retrain encodings into the MBTRAIN target state by generic priority (ENC_W options).
// - Sends the start response through the wrapper valid/busy handshake, deferring to the TX side.
// - Flags malformed encodings; optionally flags a handshake timeout.
// PARAMETERS
// - SB_MSG_WIDTH    4     width of decoded/encoded sideband message codes
// - ENC_W           3     retrain-option count; one-hot, bit k = option k, higher k = higher priority
// - RES_W           $clog2(ENC_W+1)   resolved-state width; 0 = IDLE, k+1 = option k
// - REQ_CODE        1     decoded code of PHYRETRAIN start request
// - RESP_CODE       2     encoded code of PHYRETRAIN start response
// - TIMEOUT_CYCLES  8000  cycles allowed in WAIT_REQ+SEND_RESP (timeout build only)
// PORTS
// - i_clk                       in   1             clock
// - i_rst                       in   1             asynchronous reset, active-high
// - i_phyretrain_en             in   1             LTSM enable; low forces IDLE
// - i_clear_resolved_state      in   1             clears o_resolved_state
// - i_falling_edge_busy         in   1             SB consumed message; drop valid
// - i_tx_valid                  in   1             TX sibling currently driving wrapper
// - i_SB_Busy                   in   1             sideband busy
// - i_rx_msg_valid              in   1             i_decoded_SB_msg valid this cycle
// - i_decoded_SB_msg            in   SB_MSG_WIDTH  decoded partner message
// - i_local_retrain_encoding    in   ENC_W         local request, one-hot
// - i_retrain_encoding_partner  in   ENC_W         partner request, one-hot
// - o_encoded_SB_msg_rx         out  SB_MSG_WIDTH  message to send
// - o_valid_rx                  out  1             message valid to wrapper
// - o_phyretrain_end_rx         out  1             RX handshake complete (level)
// - o_resolved_state            out  RES_W         resolved MBTRAIN target
// - o_encoding_err              out  1             either encoding not one-hot at resolve
// - o_timeout                   out  1             handshake timed out (level)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counter 0.
// - States: IDLE, WAIT_REQ, SEND_RESP, DONE, TIMEOUT. Registered; any state -> IDLE next edge when en=0.
// - IDLE -> WAIT_REQ when en=1; IDLE clears o_encoded_SB_msg_rx, o_phyretrain_end_rx, o_valid_rx,
//   o_encoding_err, o_timeout (NOT o_resolved_state).
// - WAIT_REQ -> SEND_RESP on i_rx_msg_valid && msg==REQ_CODE. Same edge: o_encoded_SB_msg_rx<=RESP_CODE;
//   o_resolved_state <= 1+index of highest set bit of (local|partner) if both one-hot, else 0 and o_encoding_err<=1.
// - SEND_RESP: o_valid_rx rises at first edge where !i_SB_Busy && !i_tx_valid && not yet sent (pending
//   request held across TX activity). o_valid_rx falls on i_falling_edge_busy; clear beats set on same cycle.
//   Falling edge of o_valid_rx (registered history) -> DONE.
// - DONE: o_phyretrain_end_rx=1 one cycle after entry, held until IDLE; further requests ignored.
// - i_clear_resolved_state has priority over a simultaneous resolve write.
// - Messages with other codes or while not in WAIT_REQ are ignored; only one response per enable.
// CONFIGURATION
// - PHYRETRAIN_RX_TIMEOUT_EN defined: counter increments each cycle in WAIT_REQ/SEND_RESP, resets on
//   entry to WAIT_REQ; count==TIMEOUT_CYCLES-1 -> TIMEOUT, o_valid_rx<=0, o_timeout<=1 held until en=0.
// - Undefined: no counter, TIMEOUT unreachable, o_timeout tied 0.
// TESTING
// - en=1, REQ, local=001 partner=100 -> resolved=3, msg=2, valid rises next cycle; busy edge -> end=1.
// - local=001 partner=001 -> resolved=1; local=011 -> resolved=0, o_encoding_err=1.
// - REQ while i_tx_valid=1 for 5 cycles -> valid rises 1 cycle after tx_valid low, single response.
// - i_falling_edge_busy with set condition same cycle -> valid stays 0.
// - en dropped in SEND_RESP with valid=1 -> next cycle IDLE, valid=0, resolved retained; clear -> 0.
// - TIMEOUT_EN, TIMEOUT_CYCLES=16, no REQ -> o_timeout=1 after 16 cycles in WAIT_REQ, end stays 0.

Source files
------------

// File: rtl/rx_phyretrain_resolver.sv
// RX-side PHYRETRAIN responder: waits for the partner start request, resolves the retrain target,
// answers over the shared sideband wrapper. Define PHYRETRAIN_RX_TIMEOUT_EN to enable the handshake timeout.
module rx_phyretrain_resolver #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int ENC_W          = 3,
  parameter int RES_W          = $clog2(ENC_W+1),
  parameter int REQ_CODE       = 1,
  parameter int RESP_CODE      = 2,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_phyretrain_en,
  input  logic                    i_clear_resolved_state,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_tx_valid,
  input  logic                    i_SB_Busy,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic [ENC_W-1:0]        i_local_retrain_encoding,
  input  logic [ENC_W-1:0]        i_retrain_encoding_partner,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_valid_rx,
  output logic                    o_phyretrain_end_rx,
  output logic [RES_W-1:0]        o_resolved_state,
  output logic                    o_encoding_err,
  output logic                    o_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_REQ, S_SEND_RESP, S_DONE, S_TIMEOUT} state_t;

  state_t                  state, state_nxt;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_nxt;
  logic                    valid_q, valid_nxt, valid_hist;
  logic                    sent_q, sent_nxt;
  logic                    end_q, end_nxt;
  logic [RES_W-1:0]        res_q, res_nxt;
  logic                    err_q, err_nxt;
  logic                    to_q, to_nxt;
  logic                    req_hit, timeout_hit;
  logic [ENC_W-1:0]        enc_or;

  // Highest set bit wins; result is 1-based so 0 stays free for IDLE.
  function automatic logic [RES_W-1:0] prio_idx(input logic [ENC_W-1:0] v);
    prio_idx = '0;
    for (int k = 0; k < ENC_W; k++)
      if (v[k]) prio_idx = RES_W'(k + 1);
  endfunction

  assign req_hit = i_rx_msg_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(REQ_CODE));
  assign enc_or  = i_local_retrain_encoding | i_retrain_encoding_partner;

`ifdef PHYRETRAIN_RX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                          cnt <= '0;
    else if (!i_phyretrain_en || state == S_IDLE)       cnt <= '0;
    else if (state == S_WAIT_REQ || state == S_SEND_RESP) cnt <= cnt + 1'b1;
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    msg_nxt   = msg_q;
    valid_nxt = valid_q;
    sent_nxt  = sent_q;
    end_nxt   = end_q;
    res_nxt   = res_q;
    err_nxt   = err_q;
    to_nxt    = to_q;
    if (!i_phyretrain_en) begin
      state_nxt = S_IDLE;
      msg_nxt   = '0;
      valid_nxt = 1'b0;
      sent_nxt  = 1'b0;
      end_nxt   = 1'b0;
      err_nxt   = 1'b0;
      to_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_WAIT_REQ;
          msg_nxt   = '0;
          valid_nxt = 1'b0;
          sent_nxt  = 1'b0;
          end_nxt   = 1'b0;
          err_nxt   = 1'b0;
          to_nxt    = 1'b0;
        end
        S_WAIT_REQ: begin
          if (timeout_hit) begin
            state_nxt = S_TIMEOUT;
            valid_nxt = 1'b0;
            to_nxt    = 1'b1;
          end else if (req_hit) begin
            state_nxt = S_SEND_RESP;
            msg_nxt   = SB_MSG_WIDTH'(RESP_CODE);
            if ($onehot(i_local_retrain_encoding) && $onehot(i_retrain_encoding_partner)) begin
              res_nxt = prio_idx(enc_or);
              err_nxt = 1'b0;
            end else begin
              res_nxt = '0;
              err_nxt = 1'b1;
            end
          end
        end
        S_SEND_RESP: begin
          if (timeout_hit) begin
            state_nxt = S_TIMEOUT;
            valid_nxt = 1'b0;
            to_nxt    = 1'b1;
          end else begin
            // Consumption by the sideband wins over a fresh launch in the same cycle.
            if (i_falling_edge_busy)
              valid_nxt = 1'b0;
            else if (!i_SB_Busy && !i_tx_valid && !sent_q) begin
              valid_nxt = 1'b1;
              sent_nxt  = 1'b1;
            end
            if (valid_hist && !valid_q)
              state_nxt = S_DONE;
          end
        end
        S_DONE:    end_nxt = 1'b1;
        S_TIMEOUT: ;
        default:   state_nxt = S_IDLE;
      endcase
    end
    if (i_clear_resolved_state)
      res_nxt = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      msg_q      <= '0;
      valid_q    <= 1'b0;
      valid_hist <= 1'b0;
      sent_q     <= 1'b0;
      end_q      <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      msg_q      <= msg_nxt;
      valid_q    <= valid_nxt;
      valid_hist <= valid_q;
      sent_q     <= sent_nxt;
      end_q      <= end_nxt;
      res_q      <= res_nxt;
      err_q      <= err_nxt;
      to_q       <= to_nxt;
    end
  end

  assign o_encoded_SB_msg_rx = msg_q;
  assign o_valid_rx          = valid_q;
  assign o_phyretrain_end_rx = end_q;
  assign o_resolved_state    = res_q;
  assign o_encoding_err      = err_q;
`ifdef PHYRETRAIN_RX_TIMEOUT_EN
  assign o_timeout           = to_q;
`else
  assign o_timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_rx_phyretrain_resolver.sv
// Directed bench for rx_phyretrain_resolver: resolve priority, deferral, handshake, enable drop, timeout.
module tb_rx_phyretrain_resolver;
  localparam int SBW = 4;
  localparam int EW  = 3;
  localparam int RW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en, clr, feb, txv, sbb, rxv;
  logic [SBW-1:0] dmsg;
  logic [EW-1:0]  loc, par;
  logic [SBW-1:0] emsg;
  logic           vld, endr, err, tmo;
  logic [RW-1:0]  res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_phyretrain_resolver #(
    .SB_MSG_WIDTH(SBW), .ENC_W(EW), .RES_W(RW),
    .REQ_CODE(1), .RESP_CODE(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_phyretrain_en(en), .i_clear_resolved_state(clr),
    .i_falling_edge_busy(feb), .i_tx_valid(txv), .i_SB_Busy(sbb), .i_rx_msg_valid(rxv),
    .i_decoded_SB_msg(dmsg), .i_local_retrain_encoding(loc), .i_retrain_encoding_partner(par),
    .o_encoded_SB_msg_rx(emsg), .o_valid_rx(vld), .o_phyretrain_end_rx(endr),
    .o_resolved_state(res), .o_encoding_err(err), .o_timeout(tmo)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse enable low then high so the FSM lands in WAIT_REQ.
  task automatic restart();
    en = 1'b0; tick();
    en = 1'b1; tick();
  endtask

  task automatic send_req(input logic [EW-1:0] l, input logic [EW-1:0] p);
    loc = l; par = p; rxv = 1'b1; dmsg = 4'd1;
    tick();
    rxv = 1'b0; dmsg = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; clr = 0; feb = 0; txv = 0; sbb = 0; rxv = 0; dmsg = 0; loc = 0; par = 0;
    tick(2);
    total++;
    if ({emsg, vld, endr, res, err, tmo} !== '0) begin
      bad++; $display("FAIL reset outputs got=%h want=0", {emsg, vld, endr, res, err, tmo});
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_basic();
    en = 1'b1; tick();
    send_req(3'b001, 3'b100);
    total++;
    if (res !== 2'd3 || emsg !== 4'd2 || vld !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL basic_resolve res=%0d msg=%0d vld=%b err=%b want 3/2/0/0", res, emsg, vld, err);
    end
    tick();
    total++;
    if (vld !== 1'b1) begin bad++; $display("FAIL basic_valid_rise got=%b want=1", vld); end
    feb = 1'b1; tick(); feb = 1'b0;
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL basic_valid_fall got=%b want=0", vld); end
    tick();
    total++;
    if (endr !== 1'b0) begin bad++; $display("FAIL basic_end_early got=%b want=0", endr); end
    tick();
    total++;
    if (endr !== 1'b1) begin bad++; $display("FAIL basic_end got=%b want=1", endr); end
    send_req(3'b010, 3'b010);
    tick();
    total++;
    if (res !== 2'd3 || vld !== 1'b0 || endr !== 1'b1) begin
      bad++; $display("FAIL done_ignores_req res=%0d vld=%b end=%b want 3/0/1", res, vld, endr);
    end
  endtask

  task automatic test_encodings();
    restart();
    send_req(3'b001, 3'b001);
    total++;
    if (res !== 2'd1 || err !== 1'b0) begin
      bad++; $display("FAIL same_enc res=%0d err=%b want 1/0", res, err);
    end
    restart();
    send_req(3'b011, 3'b001);
    total++;
    if (res !== 2'd0 || err !== 1'b1 || emsg !== 4'd2) begin
      bad++; $display("FAIL bad_enc res=%0d err=%b msg=%0d want 0/1/2", res, err, emsg);
    end
    restart();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_cleared_idle got=%b want=0", err); end
  endtask

  task automatic test_tx_defer();
    restart();
    txv = 1'b1;
    send_req(3'b100, 3'b010);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (vld !== 1'b0) begin bad++; $display("FAIL defer_hold cyc=%0d got=%b want=0", i, vld); end
    end
    txv = 1'b0; tick();
    total++;
    if (vld !== 1'b1) begin bad++; $display("FAIL defer_release got=%b want=1", vld); end
    feb = 1'b1; tick(); feb = 1'b0;
    tick(3);
    total++;
    if (vld !== 1'b0 || endr !== 1'b1 || res !== 2'd3) begin
      bad++; $display("FAIL single_resp vld=%b end=%b res=%0d want 0/1/3", vld, endr, res);
    end
  endtask

  task automatic test_clear_beats_set();
    restart();
    sbb = 1'b1;
    send_req(3'b001, 3'b001);
    tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL busy_hold got=%b want=0", vld); end
    sbb = 1'b0; feb = 1'b1; tick(); feb = 1'b0;
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL clear_beats_set got=%b want=0", vld); end
  endtask

  task automatic test_en_drop();
    restart();
    send_req(3'b010, 3'b010);
    tick();
    total++;
    if (vld !== 1'b1 || res !== 2'd2) begin
      bad++; $display("FAIL drop_pre vld=%b res=%0d want 1/2", vld, res);
    end
    en = 1'b0; tick();
    total++;
    if (vld !== 1'b0 || emsg !== 4'd0 || res !== 2'd2) begin
      bad++; $display("FAIL drop_idle vld=%b msg=%0d res=%0d want 0/0/2", vld, emsg, res);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    total++;
    if (res !== 2'd0) begin bad++; $display("FAIL clear_resolved got=%0d want=0", res); end
    en = 1'b1; tick();
    clr = 1'b1;
    send_req(3'b100, 3'b001);
    clr = 1'b0;
    total++;
    if (res !== 2'd0 || emsg !== 4'd2) begin
      bad++; $display("FAIL clear_priority res=%0d msg=%0d want 0/2", res, emsg);
    end
  endtask

  task automatic test_timeout();
    restart();
`ifdef PHYRETRAIN_RX_TIMEOUT_EN
    tick(15);
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", tmo); end
    tick();
    total++;
    if (tmo !== 1'b1 || endr !== 1'b0) begin
      bad++; $display("FAIL timeout tmo=%b end=%b want 1/0", tmo, endr);
    end
    en = 1'b0; tick();
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", tmo); end
`else
    tick(40);
    total++;
    if (tmo !== 1'b0 || endr !== 1'b0) begin
      bad++; $display("FAIL no_timeout tmo=%b end=%b want 0/0", tmo, endr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_encodings();
    test_tx_defer();
    test_clear_beats_set();
    test_en_drop();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
